// File: rtl/fetch_sequencer_pkg.sv
// Shared cycle-state, trap-cause and instruction constants for the fetch sequencer
// and its decoder.
package polaris_seq_pkg;

  typedef logic [2:0] cstate_t;

  localparam cstate_t S_EX0   = 3'd0;
  localparam cstate_t S_EX1   = 3'd1;
  localparam cstate_t S_EX2   = 3'd2;
  localparam cstate_t S_FETCH = 3'd3;

  localparam logic [1:0] CAUSE_NONE     = 2'd0;
  localparam logic [1:0] CAUSE_FETCH_TO = 2'd1;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'd2;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // An execute step is illegal if the decoder rejects the IR or names a state
  // outside the four-state cycle.
  function automatic logic is_illegal(input logic defined, input cstate_t nstate);
    return !defined || (nstate > S_FETCH);
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and the memory system (slave).
interface fetch_sequencer_if;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic [31:0] dat;

  modport master (output cyc, output stb, input ack, input dat);
  modport slave  (input cyc, input stb, output ack, output dat);
endinterface

// File: rtl/fetch_sequencer_watchdog.sv
// Counts consecutive un-acknowledged fetch cycles and flags the cycle on which
// a missing ack must become a bus-error trap.
module fetch_watchdog #(
  parameter int FETCH_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clr_i,
  input  logic inc_i,
  input  logic ack_i,
  output logic expired_o
);

  localparam logic [7:0] LAST_COUNT = 8'(FETCH_TIMEOUT - 1);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (inc_i)
      count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // A late ack on the final cycle still rescues the fetch.
  assign expired_o = (count_q == LAST_COUNT) && !ack_i;

endmodule

// File: rtl/fetch_sequencer.sv
// CPU cycle-state, IR and PC owner: runs the fetch handshake, steps the decoder's
// cycle states, and vectors illegal instructions and fetch timeouts to the trap handler.
module fetch_sequencer
  import polaris_seq_pkg::*;
#(
  parameter int              XLEN          = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR  = 64'hFFFF_FFFF_FFFF_FF00,
  parameter logic [XLEN-1:0] TRAP_VECTOR   = 64'hFFFF_FFFF_FFFF_FE00,
  parameter int              FETCH_TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [2:0]          nstate_i,
  input  logic                defined_i,
  input  logic                ir_dat_irl_i,
  fetch_sequencer_if.master   bus,
  output logic [2:0]          cstate_o,
  output logic [31:0]         ir_o,
  output logic [XLEN-1:0]     pc_o,
  output logic                trap_o,
  output logic [XLEN-1:0]     epc_o,
  output logic [1:0]          cause_o
);

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  cstate_t         cstate_q, cstate_d;
  logic [31:0]     ir_q, ir_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [1:0]      cause_q, cause_d;
  logic            trap_q, trap_d;

  logic fetching, bus_active, ack_take, illegal, timeout, trap_take, wd_expired;

  // The cycle right after a trap is an abort cycle: strobe low, no ack taken.
  assign fetching   = (cstate_q == S_FETCH);
  assign bus_active = reset_i && fetching && !trap_q;
  assign ack_take   = bus_active && bus.ack && ir_dat_irl_i;
  assign illegal    = !fetching && is_illegal(defined_i, nstate_i);
  assign timeout    = bus_active && wd_expired;
  assign trap_take  = illegal || timeout;

  fetch_watchdog #(.FETCH_TIMEOUT(FETCH_TIMEOUT)) u_watchdog (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .clr_i     (!bus_active || ack_take || trap_take),
    .inc_i     (bus_active),
    .ack_i     (ack_take),
    .expired_o (wd_expired)
  );

  always_comb begin
    cstate_d = cstate_q;
    ir_d     = ir_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    cause_d  = cause_q;
    trap_d   = 1'b0;
    if (trap_take) begin
      trap_d   = 1'b1;
      cstate_d = S_FETCH;
      pc_d     = TRAP_VECTOR;
      // PC already points past the executing instruction; a failed fetch has not advanced it.
      epc_d    = illegal ? (pc_q - PC_STEP) : pc_q;
      cause_d  = illegal ? CAUSE_ILLEGAL : CAUSE_FETCH_TO;
    end else if (!fetching) begin
      cstate_d = nstate_i;
    end else if (ack_take) begin
      ir_d     = bus.dat;
      pc_d     = pc_q + PC_STEP;
      cstate_d = nstate_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      cstate_q <= S_FETCH;
      ir_q     <= NOP_INSN;
      pc_q     <= RESET_VECTOR;
      epc_q    <= '0;
      cause_q  <= CAUSE_NONE;
      trap_q   <= 1'b0;
    end else begin
      cstate_q <= cstate_d;
      ir_q     <= ir_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      trap_q   <= trap_d;
    end
  end

  assign bus.cyc  = bus_active;
  assign bus.stb  = bus_active;
  assign cstate_o = cstate_q;
  assign ir_o     = ir_q;
  assign pc_o     = pc_q;
  assign trap_o   = trap_q;
  assign epc_o    = epc_q;
  assign cause_o  = cause_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vector table, hand-written timeout/reset/wrap
// sequences, then randomized traffic against a behavioural model.
module tb_fetch_sequencer;
  import polaris_seq_pkg::*;

  localparam int          XLEN = 64;
  localparam logic [63:0] RV   = 64'hFFFF_FFFF_FFFF_FF00;
  localparam logic [63:0] TV   = 64'hFFFF_FFFF_FFFF_FE00;
  localparam int          TO   = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  nstate = 3'd0;
  logic        defined = 1'b1;
  logic        irl = 1'b0;
  logic [2:0]  cstate;
  logic [31:0] ir;
  logic [63:0] pc, epc;
  logic        trap;
  logic [1:0]  cause;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .FETCH_TIMEOUT(TO)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .nstate_i     (nstate),
    .defined_i    (defined),
    .ir_dat_irl_i (irl),
    .bus          (bus),
    .cstate_o     (cstate),
    .ir_o         (ir),
    .pc_o         (pc),
    .trap_o       (trap),
    .epc_o        (epc),
    .cause_o      (cause)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [2:0] ns, input logic def, input logic l,
                       input logic a, input logic [31:0] d);
    nstate  = ns;
    defined = def;
    irl     = l;
    bus.ack = a;
    bus.dat = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag, input logic exp_stb);
    chk({tag, "_cstate"}, 64'(cstate), 64'(S_FETCH));
    chk({tag, "_pc"}, pc, RV);
    chk({tag, "_ir"}, 64'(ir), 64'h13);
    chk({tag, "_trap"}, 64'(trap), 64'd0);
    chk({tag, "_epc"}, epc, 64'd0);
    chk({tag, "_cause"}, 64'(cause), 64'd0);
    chk({tag, "_stb"}, 64'(bus.stb), 64'(exp_stb));
    chk({tag, "_cyc"}, 64'(bus.cyc), 64'(exp_stb));
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    drive(3'd0, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (3) step();
    check_reset_values({tag, "_held"}, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_reset_values({tag, "_rel"}, 1'b1);
  endtask

  // ---------------- behavioural reference model ----------------
  logic [2:0]  m_cs;
  logic [63:0] m_pc, m_epc;
  logic [31:0] m_ir;
  logic        m_trap;
  logic [1:0]  m_cause;
  int          m_miss;

  task automatic model_reset();
    m_cs = 3'd3; m_pc = RV; m_ir = 32'h13; m_trap = 1'b0;
    m_epc = '0; m_cause = 2'd0; m_miss = 0;
  endtask

  // Applies the current inputs to the model state, as the next clock edge would.
  task automatic model_step();
    bit fetching, on_bus, got, bad, late;
    fetching = (m_cs == 3'd3);
    on_bus   = fetching && !m_trap;
    got      = on_bus && bus.ack && irl;
    bad      = !fetching && (!defined || nstate > 3'd3);
    late     = on_bus && !got && (m_miss + 1 == TO);
    if (bad || late) begin
      m_epc   = bad ? m_pc - 64'd4 : m_pc;
      m_cause = bad ? 2'd2 : 2'd1;
      m_pc    = TV;
      m_cs    = 3'd3;
      m_trap  = 1'b1;
      m_miss  = 0;
    end else begin
      m_trap = 1'b0;
      if (!fetching) begin
        m_cs   = nstate;
        m_miss = 0;
      end else if (got) begin
        m_ir   = bus.dat;
        m_pc   = m_pc + 64'd4;
        m_cs   = nstate;
        m_miss = 0;
      end else if (on_bus) begin
        m_miss++;
      end
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [2:0]  ns;
    logic        def;
    logic        irl;
    logic        ack;
    logic [31:0] dat;
    logic [2:0]  e_cs;
    logic [63:0] e_pc;
    logic [31:0] e_ir;
    logic        e_stb;
    logic        e_trap;
    logic [1:0]  e_cause;
    logic [63:0] e_epc;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int ackp;
    bus.ack = 1'b0;
    bus.dat = 32'h0;

    tbl[0] = '{S_EX0, 1'b1, 1'b1, 1'b1, 32'h0020_0093, S_EX0,   RV + 64'd4, 32'h0020_0093, 1'b0, 1'b0, 2'd0, 64'd0};
    tbl[1] = '{S_EX1, 1'b1, 1'b0, 1'b0, 32'h0,         S_EX1,   RV + 64'd4, 32'h0020_0093, 1'b0, 1'b0, 2'd0, 64'd0};
    tbl[2] = '{S_EX2, 1'b1, 1'b0, 1'b0, 32'h0,         S_EX2,   RV + 64'd4, 32'h0020_0093, 1'b0, 1'b0, 2'd0, 64'd0};
    tbl[3] = '{3'd3,  1'b1, 1'b0, 1'b0, 32'h0,         S_FETCH, RV + 64'd4, 32'h0020_0093, 1'b1, 1'b0, 2'd0, 64'd0};
    tbl[4] = '{S_EX1, 1'b1, 1'b1, 1'b1, 32'h1234_5678, S_EX1,   RV + 64'd8, 32'h1234_5678, 1'b0, 1'b0, 2'd0, 64'd0};
    tbl[5] = '{S_EX2, 1'b0, 1'b0, 1'b0, 32'h0,         S_FETCH, TV,         32'h1234_5678, 1'b0, 1'b1, CAUSE_ILLEGAL, RV + 64'd4};
    tbl[6] = '{S_EX0, 1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF, S_FETCH, TV,         32'h1234_5678, 1'b1, 1'b0, CAUSE_ILLEGAL, RV + 64'd4};
    tbl[7] = '{S_EX0, 1'b1, 1'b0, 1'b1, 32'hBAD0_0000, S_FETCH, TV,         32'h1234_5678, 1'b1, 1'b0, CAUSE_ILLEGAL, RV + 64'd4};
    tbl[8] = '{S_EX2, 1'b1, 1'b1, 1'b1, 32'h0000_0093, S_EX2,   TV + 64'd4, 32'h0000_0093, 1'b0, 1'b0, CAUSE_ILLEGAL, RV + 64'd4};
    tbl[9] = '{3'd5,  1'b1, 1'b0, 1'b0, 32'h0,         S_FETCH, TV,         32'h0000_0093, 1'b0, 1'b1, CAUSE_ILLEGAL, TV};

    do_reset("rst1");

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].ns, tbl[i].def, tbl[i].irl, tbl[i].ack, tbl[i].dat);
      step();
      chk($sformatf("vec%0d_cstate", i), 64'(cstate), 64'(tbl[i].e_cs));
      chk($sformatf("vec%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("vec%0d_ir", i), 64'(ir), 64'(tbl[i].e_ir));
      chk($sformatf("vec%0d_stb", i), 64'(bus.stb), 64'(tbl[i].e_stb));
      chk($sformatf("vec%0d_cyc", i), 64'(bus.cyc), 64'(tbl[i].e_stb));
      chk($sformatf("vec%0d_trap", i), 64'(trap), 64'(tbl[i].e_trap));
      chk($sformatf("vec%0d_cause", i), 64'(cause), 64'(tbl[i].e_cause));
      chk($sformatf("vec%0d_epc", i), epc, tbl[i].e_epc);
    end

    // Abort cycle after the illegal trap, then 16 un-acked fetch cycles.
    drive(3'd0, 1'b1, 1'b1, 1'b0, 32'h0);
    step();
    chk("abort_trap", 64'(trap), 64'd0);
    chk("abort_stb_back", 64'(bus.stb), 64'd1);
    for (int i = 1; i <= TO; i++) begin
      step();
      chk($sformatf("to_trap_edge%0d", i), 64'(trap), (i == TO) ? 64'd1 : 64'd0);
    end
    chk("to_cause", 64'(cause), 64'(CAUSE_FETCH_TO));
    chk("to_epc", epc, TV);
    chk("to_pc", pc, TV);
    chk("to_stb_abort", 64'(bus.stb), 64'd0);

    // Same again, but the ack lands on the final cycle and wins.
    step();
    for (int i = 1; i < TO; i++) step();
    chk("late_ack_pre_trap", 64'(trap), 64'd0);
    drive(S_EX0, 1'b1, 1'b1, 1'b1, 32'hCAFE_0013);
    step();
    chk("late_ack_trap", 64'(trap), 64'd0);
    chk("late_ack_ir", 64'(ir), 64'hCAFE_0013);
    chk("late_ack_pc", pc, TV + 64'd4);
    chk("late_ack_cstate", 64'(cstate), 64'(S_EX0));
    chk("late_ack_cause_held", 64'(cause), 64'(CAUSE_FETCH_TO));

    // Asynchronous reset mid-execute, between clock edges.
    drive(S_EX1, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    drive(S_EX2, 1'b1, 1'b0, 1'b0, 32'h0);
    step();
    chk("pre_async_cstate", 64'(cstate), 64'(S_EX2));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("async_rel_stb", 64'(bus.stb), 64'd1);

    // Walk the PC up to the top of the address space and wrap.
    for (int i = 0; i < 63; i++) begin
      drive(3'd3, 1'b1, 1'b1, 1'b1, 32'(i));
      step();
    end
    chk("wrap_pre_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(3'd3, 1'b1, 1'b1, 1'b1, 32'h0000_0113);
    step();
    chk("wrap_pc", pc, 64'd0);
    chk("wrap_trap", 64'(trap), 64'd0);
    chk("wrap_ir", 64'(ir), 64'h0000_0113);
    chk("wrap_stb", 64'(bus.stb), 64'd1);

    // Randomized traffic against the model.
    do_reset("rst2");
    model_reset();
    ackp = 90;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) ackp = (c / 250 % 3 == 0) ? 90 : ((c / 250 % 3 == 1) ? 30 : 4);
      drive(($urandom_range(0, 19) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
            $urandom_range(0, 29) != 0,
            $urandom_range(0, 9) != 0,
            $urandom_range(0, 99) < ackp,
            $urandom);
      model_step();
      step();
      chk("rnd_cstate", 64'(cstate), 64'(m_cs));
      chk("rnd_pc", pc, m_pc);
      chk("rnd_ir", 64'(ir), 64'(m_ir));
      chk("rnd_trap", 64'(trap), 64'(m_trap));
      chk("rnd_epc", epc, m_epc);
      chk("rnd_cause", 64'(cause), 64'(m_cause));
      chk("rnd_stb", 64'(bus.stb), 64'((m_cs == 3'd3) && !m_trap));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
